// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter
//  Description : Streams one SPRITE_W x SPRITE_H sprite into a frame manager's
//                write slot. Waits for a slot offered to SOURCE_ID, latches
//                the sprite position and enable, reads the sprite ROM
//                row-major, and presents one pixel per cycle with a
//                transparency flag for colour-keyed or off-screen pixels.
//  Ports       : clk, reset               - clock, synchronous active-high reset
//                write_awaited,
//                write_source_sel         - slot offer and target source index
//                sprite_x, sprite_y,
//                sprite_enable            - sprite placement, sampled at slot start
//                rom_addr, rom_data       - sprite ROM (1-cycle read latency)
//                write_active             - pixel outputs valid this cycle
//                write_x_addr,
//                write_y_addr             - pixel coordinate
//                write_color_data,
//                write_transparent        - pixel colour, suppress-write flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
  parameter int SOURCE_ID   = 0,
  parameter int SEL_WIDTH   = 1,
  parameter int DRAW_WIDTH  = 640,
  parameter int DRAW_HEIGHT = 480,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int COLOR_DEPTH = 9,
  parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_KEY = '1,
  localparam int XW   = $clog2(DRAW_WIDTH),
  localparam int YW   = $clog2(DRAW_HEIGHT),
  localparam int NPIX = SPRITE_W * SPRITE_H,
  localparam int AW   = $clog2(NPIX),
  localparam int CW   = $clog2(SPRITE_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_awaited,
  input  logic [SEL_WIDTH-1:0]   write_source_sel,
  input  logic [XW-1:0]          sprite_x,
  input  logic [YW-1:0]          sprite_y,
  input  logic                   sprite_enable,
  output logic [AW-1:0]          rom_addr,
  input  logic [COLOR_DEPTH-1:0] rom_data,
  output logic                   write_active,
  output logic [XW-1:0]          write_x_addr,
  output logic [YW-1:0]          write_y_addr,
  output logic [COLOR_DEPTH-1:0] write_color_data,
  output logic                   write_transparent
);

  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_FETCH = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_lx;
  logic [YW-1:0]   r_ly;
  logic            r_len;
  logic [AW-1:0]   r_cnt;    // index of the pixel captured on the next DRAW edge

  logic            w_hit;
  logic [CW-1:0]   w_col;
  logic [AW-CW-1:0] w_row;
  logic [XW:0]     w_sum_x;  // one bit wider so off-screen sums never alias on-screen
  logic [YW:0]     w_sum_y;
  logic            w_clip;
  logic            w_key;
  logic            w_last;

  assign w_hit   = write_awaited && (write_source_sel == SEL_WIDTH'(SOURCE_ID));
  assign w_col   = r_cnt[CW-1:0];
  assign w_row   = r_cnt[AW-1:CW];
  assign w_sum_x = {1'b0, r_lx} + (XW+1)'(w_col);
  assign w_sum_y = {1'b0, r_ly} + (YW+1)'(w_row);
  assign w_clip  = (w_sum_x >= (XW+1)'(DRAW_WIDTH)) || (w_sum_y >= (YW+1)'(DRAW_HEIGHT));
  assign w_key   = (rom_data == TRANSPARENT_KEY);
  assign w_last  = (r_cnt == AW'(NPIX - 1));

  // ROM address runs two edges ahead of the captured pixel: address k is on
  // the bus during one cycle, the ROM returns it the next, and it is
  // registered onto the pixel outputs on the edge after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_ARM;
      r_lx              <= '0;
      r_ly              <= '0;
      r_len             <= 1'b0;
      r_cnt             <= '0;
      rom_addr          <= '0;
      write_active      <= 1'b0;
      write_x_addr      <= '0;
      write_y_addr      <= '0;
      write_color_data  <= '0;
      write_transparent <= 1'b1;
    end else begin
      case (r_state)
        S_ARM: begin
          write_active      <= 1'b0;
          write_transparent <= 1'b1;
          rom_addr          <= '0;
          if (w_hit) begin
            r_lx    <= sprite_x;
            r_ly    <= sprite_y;
            r_len   <= sprite_enable;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_cnt    <= '0;
          rom_addr <= AW'(1);
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          write_active     <= 1'b1;
          write_x_addr     <= w_sum_x[XW-1:0];
          write_y_addr     <= w_sum_y[YW-1:0];
          write_color_data <= rom_data;
          if (!r_len) begin
            // Disabled sprite: acknowledge the slot with one suppressed pixel.
            write_transparent <= 1'b1;
            r_state           <= S_DONE;
          end else begin
            write_transparent <= w_key || w_clip;
            rom_addr          <= r_cnt + AW'(2);
            r_cnt             <= r_cnt + AW'(1);
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Hold here while the offer is still up so a stale write_awaited
          // cannot start a second burst.
          write_active      <= 1'b0;
          write_transparent <= 1'b1;
          rom_addr          <= '0;
          if (!write_awaited) begin
            r_state <= S_ARM;
          end
        end
        default: r_state <= S_ARM;
      endcase
    end
  end

endmodule
`default_nettype wire
